ahb3lite_master_arb: RTL and testbench
======================================

AHB3LITE_MASTER_ARB -- requirements
Module: ahb3lite_master_arb

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, the number of consecutive transfers granted to one port while the other port waits (1..15).
REQ-002 SHALL have port clk_i  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port sHADDR  in  [1:0][31:0]  per-port address (port 0 = CPU, port 1 = DMA master).
REQ-005 SHALL have port sHWDATA  in  [1:0][31:0]  per-port write data.
REQ-006 SHALL have port sHWRITE  in  [1:0]  per-port write flag.
REQ-007 SHALL have port sHSIZE  in  [1:0][2:0]  per-port size.
REQ-008 SHALL have port sHTRANS  in  [1:0][1:0]  per-port transfer type.
REQ-009 SHALL have port sHRDATA  out  [1:0][31:0]  per-port read data.
REQ-010 SHALL have port sHREADYOUT  out  [1:0]  per-port ready.
REQ-011 SHALL have port sHRESP  out  [1:0]  per-port error response.
REQ-012 SHALL have bus ports mHADDR  out  32, mHWDATA  out  32, mHWRITE  out  1, mHSIZE  out  3 and mHTRANS  out  2, the shared AHB3-Lite bus signals.
REQ-013 SHALL have bus ports mHRDATA  in  32, mHREADY  in  1 and mHRESP  in  1, the shared-bus responses.
REQ-014 SHALL have port mHMASTER  out  1  current or last bus owner.

Function
REQ-015 Sampling: a port transfer SHALL be sampled at a clock edge when sHREADYOUT[i]=1 and sHTRANS[i][1]=1.
- A sampled transfer loads hold register i (addr, write, size) and sets hold_vld[i].
- IDLE and BUSY transfers are never sampled.
REQ-016 sHREADYOUT[i] SHALL be 1 when hold_vld[i]=0, or when port i owns the DATA state and mHREADY=1; otherwise it SHALL be 0.
REQ-017 hold_vld[i] SHALL clear on completion of port i's transfer, unless a new transfer is sampled on the same edge.
REQ-018 FSM states SHALL be ARB and DATA.
- ARB: select a winner. If it exists, drive mHTRANS=NONSEQ with that port's hold fields; if mHREADY=1, latch owner and go to DATA.
- ARB with no hold_vld: mHTRANS=IDLE and mHADDR/mHWRITE/mHSIZE=0.
REQ-019 DATA: mHTRANS SHALL be IDLE, and mHWDATA SHALL be sHWDATA[owner].
- sHREADYOUT[owner]=mHREADY and sHRESP[owner]=mHRESP.
- The two-cycle ERROR response passes through unchanged.
- Return to ARB on mHREADY=1.
REQ-020 Winner selection:
- The last owner wins if hold_vld[last] and hold_cnt<MAX_HOLD.
- Otherwise the other port wins if it is valid; otherwise the last owner wins.
REQ-021 hold_cnt SHALL be 4 bits: set to 1 on an owner change, incremented (saturating at 15) on a repeat grant.
REQ-022 sHRDATA[0] and sHRDATA[1] SHALL both equal mHRDATA; sHRESP of the non-owner SHALL be 0.
REQ-023 mHMASTER SHALL equal the owner latched on ARB->DATA.
REQ-024 Latency SHALL be fixed for a zero-wait bus.
- Transfer sampled at edge k: bus address phase in cycle k+1, bus data phase in cycle k+2.
- The port sees exactly one inserted wait state.
- Throughput is one transfer per two cycles.
REQ-025 Simultaneous first requests from both ports after reset SHALL grant port 0 first.

Reset
REQ-026 While rst_i=1 at an edge, the block SHALL reset to the following values; a reset mid-transfer abandons the transfer with no completion to either port.
- FSM=ARB, hold_vld=0, hold_cnt=0, last owner=1, mHMASTER=0.
- Next cycle: mHTRANS=IDLE, mHADDR/mHWRITE/mHSIZE=0, sHREADYOUT=2'b11, sHRESP=0.

Configuration
REQ-027 Macro AHB3LITE_MASTER_ARB_LOCK_EN SHALL control locked-transfer support.
- With it defined: add ports sHMASTLOCK in [1:0] and mHMASTLOCK out 1, sample lock into the hold register and drive it on mHMASTLOCK in ARB.
- lock_r is set when a locked transfer completes. It clears when the owner completes an unlocked transfer, or when the owner shows HTRANS=IDLE with sHMASTLOCK=0 and hold empty.
- While lock_r=1, the owner always wins, overriding MAX_HOLD.
- Without the macro: the ports are absent and there is no locking.

Verification
REQ-028 Port0 single write 0x100/0xA5A5A5A5, zero-wait slave -> mHADDR=0x100 NONSEQ cycle k+1, mHWDATA=0xA5A5A5A5 cycle k+2, sHREADYOUT[0] low exactly one cycle.
REQ-029 Both ports request continuously, MAX_HOLD=4 -> grants 0,0,0,0,1,1,1,1,0...; mHMASTER tracks the owner.
REQ-030 Slave ERROR on port1 read -> sHRESP[1]=1 for two cycles with sHREADYOUT[1]=0 then 1; port0 sHRESP=0 throughout.
REQ-031 rst_i asserted during DATA with mHREADY=0 -> next cycle mHTRANS=IDLE, sHREADYOUT=2'b11, hold_vld=0.
REQ-032 LOCK_EN defined, port0 issues 6 locked transfers while port1 waits -> port0 keeps the bus for all 6; port1 is granted after the unlocked seventh.

Source files
------------

// File: rtl/ahb3lite_master_arb.sv
// ---------------------------------------------------------------------------
// ahb3lite_master_arb
//
// Purpose:
//   Two-port AHB3-Lite master arbiter. Port 0 is the CPU and port 1 is the
//   DMA master. Each port's address phase is captured into a per-port hold
//   register. A two-state FSM (ARB/DATA) replays the held transfer on the
//   shared bus. The same owner keeps the bus for at most MAX_HOLD consecutive
//   grants while the other port is waiting.
//
// Optional feature:
//   AHB3LITE_MASTER_ARB_LOCK_EN adds sHMASTLOCK/mHMASTLOCK and locked-sequence
//   support. While a lock is active, the owner keeps the bus.
//
// Handshake:
//   A port transfer is accepted on an edge where sHREADYOUT[i]=1 and
//   sHTRANS[i] is NONSEQ/SEQ. The bus transfer is issued on an edge where
//   mHTRANS=NONSEQ and mHREADY=1. It completes on the edge where the data
//   phase sees mHREADY=1.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   sHADDR/sHWDATA/sHWRITE   per-port AHB request signals
//   sHSIZE/sHTRANS
//   sHRDATA/sHREADYOUT/sHRESP per-port AHB responses
//   mHADDR/mHWDATA/mHWRITE   shared bus request signals
//   mHSIZE/mHTRANS
//   mHRDATA/mHREADY/mHRESP   shared bus responses
//   mHMASTER                 current or last bus owner
//   o_dbg_state              FSM state (0 = ARB, 1 = DATA)
//   o_dbg_hold_vld           per-port hold-register valid flags
// ---------------------------------------------------------------------------
module ahb3lite_master_arb #(
    parameter int MAX_HOLD = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0][31:0] sHADDR,
    input  logic [1:0][31:0] sHWDATA,
    input  logic [1:0]       sHWRITE,
    input  logic [1:0][2:0]  sHSIZE,
    input  logic [1:0][1:0]  sHTRANS,
`ifdef AHB3LITE_MASTER_ARB_LOCK_EN
    input  logic [1:0]       sHMASTLOCK,
    output logic             mHMASTLOCK,
`endif
    output logic [1:0][31:0] sHRDATA,
    output logic [1:0]       sHREADYOUT,
    output logic [1:0]       sHRESP,
    output logic [31:0]      mHADDR,
    output logic [31:0]      mHWDATA,
    output logic             mHWRITE,
    output logic [2:0]       mHSIZE,
    output logic [1:0]       mHTRANS,
    input  logic [31:0]      mHRDATA,
    input  logic             mHREADY,
    input  logic             mHRESP,
    output logic             mHMASTER,
    output logic             o_dbg_state,
    output logic [1:0]       o_dbg_hold_vld
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0][31:0]  r_hold_addr;
    logic [1:0]        r_hold_write;
    logic [1:0][2:0]   r_hold_size;
    logic [1:0]        r_hold_vld;
    logic [3:0]        r_hold_cnt;
    logic              r_last;
    logic              r_master;

    logic [1:0]        w_ready;
    logic [1:0]        w_sample;
    logic [1:0]        w_done;
    logic              w_other;
    logic              w_last_keep;
    logic              w_winner;
    logic              w_win_vld;
    logic              w_grant;
    logic              w_unused_htrans0;

`ifdef AHB3LITE_MASTER_ARB_LOCK_EN
    logic [1:0]        r_hold_lock;
    logic              r_lock;
`endif

    // Only HTRANS[1] decides whether a transfer is taken.
    // The lock release check looks at the full IDLE encoding.
    assign w_unused_htrans0 = sHTRANS[0][0] ^ sHTRANS[1][0];

    // Per-port ready, acceptance and completion.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_done[i]   = (r_state == ST_DATA) && (r_master == 1'(i)) && mHREADY;
            w_ready[i]  = ~r_hold_vld[i] | w_done[i];
            w_sample[i] = w_ready[i] & sHTRANS[i][1];
        end
    end

    // Winner selection. After reset r_hold_cnt is 0, so port 0 wins the
    // first simultaneous request even though the last owner resets to 1.
    assign w_other     = ~r_last;
    assign w_last_keep = r_hold_vld[r_last] && (r_hold_cnt != 4'd0) &&
                         (r_hold_cnt < HOLD_LIM);

    always_comb begin
        w_winner = r_last;
        if (w_last_keep) begin
            w_winner = r_last;
        end else if (r_hold_vld[w_other]) begin
            w_winner = w_other;
        end
        w_win_vld = r_hold_vld[w_winner];
`ifdef AHB3LITE_MASTER_ARB_LOCK_EN
        // While locked, the non-owner cannot win even if the owner is idle.
        if (r_lock) begin
            w_winner  = r_last;
            w_win_vld = r_hold_vld[r_last];
        end
`endif
    end

    // FSM next state and bus outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        mHTRANS     = 2'b00;
        mHADDR      = 32'd0;
        mHWRITE     = 1'b0;
        mHSIZE      = 3'd0;
        mHWDATA     = 32'd0;
`ifdef AHB3LITE_MASTER_ARB_LOCK_EN
        mHMASTLOCK  = 1'b0;
`endif
        case (r_state)
            ST_ARB: begin
                if (w_win_vld) begin
                    mHTRANS = 2'b10;
                    mHADDR  = r_hold_addr[w_winner];
                    mHWRITE = r_hold_write[w_winner];
                    mHSIZE  = r_hold_size[w_winner];
`ifdef AHB3LITE_MASTER_ARB_LOCK_EN
                    mHMASTLOCK = r_hold_lock[w_winner];
`endif
                    if (mHREADY) begin
                        w_grant     = 1'b1;
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                mHWDATA = sHWDATA[r_master];
                if (mHREADY) begin
                    w_state_nxt = ST_ARB;
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    // Port responses. Read data is broadcast to both ports.
    // The response is routed only to the owner during DATA.
    always_comb begin
        sHRDATA[0] = mHRDATA;
        sHRDATA[1] = mHRDATA;
        sHREADYOUT = w_ready;
        sHRESP     = 2'b00;
        if (r_state == ST_DATA) begin
            sHRESP[r_master] = mHRESP;
        end
    end

    assign mHMASTER       = r_master;
    assign o_dbg_state    = r_state;
    assign o_dbg_hold_vld = r_hold_vld;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_ARB;
            r_hold_addr  <= '0;
            r_hold_write <= '0;
            r_hold_size  <= '0;
            r_hold_vld   <= '0;
            r_hold_cnt   <= 4'd0;
            r_last       <= 1'b1;
            r_master     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            for (int i = 0; i < 2; i++) begin
                if (w_sample[i]) begin
                    r_hold_addr[i]  <= sHADDR[i];
                    r_hold_write[i] <= sHWRITE[i];
                    r_hold_size[i]  <= sHSIZE[i];
                    r_hold_vld[i]   <= 1'b1;
                end else if (w_done[i]) begin
                    r_hold_vld[i]   <= 1'b0;
                end
            end
            if (w_grant) begin
                r_master <= w_winner;
                r_last   <= w_winner;
                if (w_winner != r_last) begin
                    r_hold_cnt <= 4'd1;
                end else if (r_hold_cnt != 4'hF) begin
                    r_hold_cnt <= r_hold_cnt + 4'd1;
                end
            end
        end
    end

`ifdef AHB3LITE_MASTER_ARB_LOCK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold_lock <= '0;
            r_lock      <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_sample[i]) begin
                    r_hold_lock[i] <= sHMASTLOCK[i];
                end
            end
            if ((r_state == ST_DATA) && mHREADY) begin
                // Completion: a locked transfer holds the lock.
                // An unlocked transfer releases it.
                r_lock <= r_hold_lock[r_master];
            end else if ((sHTRANS[r_last] == 2'b00) && !sHMASTLOCK[r_last] &&
                         !r_hold_vld[r_last]) begin
                r_lock <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ahb3lite_master_arb.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_master_arb
//
// Directed bench for ahb3lite_master_arb with MAX_HOLD=4. Each scenario task
// drives the ports and the bus slave, then compares the outputs against
// hand-computed values. Inputs change 1 time unit after a rising edge.
// Outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_ahb3lite_master_arb;

    logic             clk_i;
    logic             rst_i;
    logic [1:0][31:0] sHADDR;
    logic [1:0][31:0] sHWDATA;
    logic [1:0]       sHWRITE;
    logic [1:0][2:0]  sHSIZE;
    logic [1:0][1:0]  sHTRANS;
    logic [1:0][31:0] sHRDATA;
    logic [1:0]       sHREADYOUT;
    logic [1:0]       sHRESP;
    logic [31:0]      mHADDR;
    logic [31:0]      mHWDATA;
    logic             mHWRITE;
    logic [2:0]       mHSIZE;
    logic [1:0]       mHTRANS;
    logic [31:0]      mHRDATA;
    logic             mHREADY;
    logic             mHRESP;
    logic             mHMASTER;
    logic             o_dbg_state;
    logic [1:0]       o_dbg_hold_vld;
`ifdef AHB3LITE_MASTER_ARB_LOCK_EN
    logic [1:0]       sHMASTLOCK;
    logic             mHMASTLOCK;
`endif

    int total = 0;
    int bad   = 0;

    ahb3lite_master_arb #(.MAX_HOLD(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .sHADDR         (sHADDR),
        .sHWDATA        (sHWDATA),
        .sHWRITE        (sHWRITE),
        .sHSIZE         (sHSIZE),
        .sHTRANS        (sHTRANS),
`ifdef AHB3LITE_MASTER_ARB_LOCK_EN
        .sHMASTLOCK     (sHMASTLOCK),
        .mHMASTLOCK     (mHMASTLOCK),
`endif
        .sHRDATA        (sHRDATA),
        .sHREADYOUT     (sHREADYOUT),
        .sHRESP         (sHRESP),
        .mHADDR         (mHADDR),
        .mHWDATA        (mHWDATA),
        .mHWRITE        (mHWRITE),
        .mHSIZE         (mHSIZE),
        .mHTRANS        (mHTRANS),
        .mHRDATA        (mHRDATA),
        .mHREADY        (mHREADY),
        .mHRESP         (mHRESP),
        .mHMASTER       (mHMASTER),
        .o_dbg_state    (o_dbg_state),
        .o_dbg_hold_vld (o_dbg_hold_vld)
    );

    // Clock and reset.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        sHADDR     = '0;
        sHWDATA    = '0;
        sHWRITE    = '0;
        sHSIZE     = '0;
        sHTRANS    = '0;
        mHRDATA    = 32'd0;
        mHREADY    = 1'b1;
        mHRESP     = 1'b0;
`ifdef AHB3LITE_MASTER_ARB_LOCK_EN
        sHMASTLOCK = '0;
`endif
        step();
        step();
        rst_i = 1'b0;
    endtask

    // Scenario tasks.
    task automatic test_reset();
        do_reset();
        #1;
        total++; if (mHTRANS !== 2'b00) begin bad++; $display("FAIL rst_htrans got=%0h exp=0", mHTRANS); end
        total++; if (mHADDR !== 32'd0) begin bad++; $display("FAIL rst_haddr got=%0h exp=0", mHADDR); end
        total++; if (mHWRITE !== 1'b0) begin bad++; $display("FAIL rst_hwrite got=%0b exp=0", mHWRITE); end
        total++; if (mHSIZE !== 3'd0) begin bad++; $display("FAIL rst_hsize got=%0h exp=0", mHSIZE); end
        total++; if (sHREADYOUT !== 2'b11) begin bad++; $display("FAIL rst_readyout got=%b exp=11", sHREADYOUT); end
        total++; if (sHRESP !== 2'b00) begin bad++; $display("FAIL rst_resp got=%b exp=00", sHRESP); end
        total++; if (mHMASTER !== 1'b0) begin bad++; $display("FAIL rst_master got=%0b exp=0", mHMASTER); end
        total++; if (o_dbg_state !== 1'b0) begin bad++; $display("FAIL rst_state got=%0b exp=0", o_dbg_state); end
        total++; if (o_dbg_hold_vld !== 2'b00) begin bad++; $display("FAIL rst_hold_vld got=%b exp=00", o_dbg_hold_vld); end
    endtask

    task automatic test_single_write();
        do_reset();
        sHTRANS[0] = 2'b10;
        sHADDR[0]  = 32'h100;
        sHWRITE[0] = 1'b1;
        sHSIZE[0]  = 3'd2;
        #1;
        total++; if (sHREADYOUT[0] !== 1'b1) begin bad++; $display("FAIL sw_ready_k got=%0b exp=1", sHREADYOUT[0]); end
        step();
        sHTRANS[0] = 2'b00;
        sHWDATA[0] = 32'hA5A5A5A5;
        #1;
        total++; if (mHTRANS !== 2'b10) begin bad++; $display("FAIL sw_htrans_k1 got=%0h exp=2", mHTRANS); end
        total++; if (mHADDR !== 32'h100) begin bad++; $display("FAIL sw_haddr_k1 got=%0h exp=100", mHADDR); end
        total++; if (mHWRITE !== 1'b1) begin bad++; $display("FAIL sw_hwrite_k1 got=%0b exp=1", mHWRITE); end
        total++; if (mHSIZE !== 3'd2) begin bad++; $display("FAIL sw_hsize_k1 got=%0h exp=2", mHSIZE); end
        total++; if (sHREADYOUT[0] !== 1'b0) begin bad++; $display("FAIL sw_ready_k1 got=%0b exp=0", sHREADYOUT[0]); end
        step();
        #1;
        total++; if (mHTRANS !== 2'b00) begin bad++; $display("FAIL sw_htrans_k2 got=%0h exp=0", mHTRANS); end
        total++; if (mHWDATA !== 32'hA5A5A5A5) begin bad++; $display("FAIL sw_hwdata_k2 got=%0h exp=a5a5a5a5", mHWDATA); end
        total++; if (sHREADYOUT[0] !== 1'b1) begin bad++; $display("FAIL sw_ready_k2 got=%0b exp=1", sHREADYOUT[0]); end
        total++; if (o_dbg_state !== 1'b1) begin bad++; $display("FAIL sw_state_k2 got=%0b exp=1", o_dbg_state); end
        total++; if (mHMASTER !== 1'b0) begin bad++; $display("FAIL sw_master_k2 got=%0b exp=0", mHMASTER); end
        step();
        #1;
        total++; if (mHTRANS !== 2'b00) begin bad++; $display("FAIL sw_htrans_k3 got=%0h exp=0", mHTRANS); end
        total++; if (sHREADYOUT !== 2'b11) begin bad++; $display("FAIL sw_ready_k3 got=%b exp=11", sHREADYOUT); end
    endtask

    task automatic test_round_robin();
        logic exp_grant [10];
        logic pend;
        logic pend_vld;
        logic got;
        int   n;
        exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        pend_vld  = 1'b0;
        pend      = 1'b0;
        n         = 0;
        do_reset();
        sHTRANS[0] = 2'b10; sHADDR[0] = 32'h1000;
        sHTRANS[1] = 2'b10; sHADDR[1] = 32'h2000;
        for (int c = 0; c < 60 && n < 10; c++) begin
            #1;
            if (pend_vld) begin
                total++;
                if (mHMASTER !== pend) begin bad++; $display("FAIL rr_master got=%0b exp=%0b", mHMASTER, pend); end
                pend_vld = 1'b0;
            end
            if (mHTRANS == 2'b10) begin
                got = (mHADDR == 32'h2000);
                total++;
                if (got !== exp_grant[n]) begin bad++; $display("FAIL rr_grant%0d got=%0b exp=%0b", n, got, exp_grant[n]); end
                pend     = got;
                pend_vld = 1'b1;
                n++;
            end
            step();
        end
        total++; if (n != 10) begin bad++; $display("FAIL rr_timeout got=%0d exp=10", n); end
        sHTRANS = '0;
    endtask

    task automatic test_error();
        do_reset();
        sHTRANS[1] = 2'b10; sHADDR[1] = 32'h300; sHWRITE[1] = 1'b0;
        step();
        sHTRANS[1] = 2'b00;
        #1;
        total++; if (mHADDR !== 32'h300) begin bad++; $display("FAIL err_haddr got=%0h exp=300", mHADDR); end
        step();
        mHREADY = 1'b0; mHRESP = 1'b1; mHRDATA = 32'hCAFEF00D;
        #1;
        total++; if (sHRESP !== 2'b10) begin bad++; $display("FAIL err_resp_c1 got=%b exp=10", sHRESP); end
        total++; if (sHREADYOUT[1] !== 1'b0) begin bad++; $display("FAIL err_ready_c1 got=%0b exp=0", sHREADYOUT[1]); end
        total++; if (sHRDATA[0] !== 32'hCAFEF00D) begin bad++; $display("FAIL err_rdata0 got=%0h exp=cafef00d", sHRDATA[0]); end
        total++; if (sHRDATA[1] !== 32'hCAFEF00D) begin bad++; $display("FAIL err_rdata1 got=%0h exp=cafef00d", sHRDATA[1]); end
        step();
        mHREADY = 1'b1; mHRESP = 1'b1;
        #1;
        total++; if (sHRESP !== 2'b10) begin bad++; $display("FAIL err_resp_c2 got=%b exp=10", sHRESP); end
        total++; if (sHREADYOUT !== 2'b11) begin bad++; $display("FAIL err_ready_c2 got=%b exp=11", sHREADYOUT); end
        total++; if (mHMASTER !== 1'b1) begin bad++; $display("FAIL err_master got=%0b exp=1", mHMASTER); end
        step();
        mHRESP = 1'b0;
        #1;
        total++; if (sHRESP !== 2'b00) begin bad++; $display("FAIL err_resp_c3 got=%b exp=00", sHRESP); end
        total++; if (o_dbg_state !== 1'b0) begin bad++; $display("FAIL err_state_c3 got=%0b exp=0", o_dbg_state); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sHTRANS[0] = 2'b10; sHADDR[0] = 32'h400; sHWRITE[0] = 1'b1;
        step();
        sHTRANS[0] = 2'b00;
        step();
        mHREADY = 1'b0;
        rst_i   = 1'b1;
        #1;
        total++; if (sHREADYOUT[0] !== 1'b0) begin bad++; $display("FAIL rm_stall got=%0b exp=0", sHREADYOUT[0]); end
        step();
        rst_i = 1'b0;
        #1;
        total++; if (mHTRANS !== 2'b00) begin bad++; $display("FAIL rm_htrans got=%0h exp=0", mHTRANS); end
        total++; if (sHREADYOUT !== 2'b11) begin bad++; $display("FAIL rm_ready got=%b exp=11", sHREADYOUT); end
        total++; if (o_dbg_hold_vld !== 2'b00) begin bad++; $display("FAIL rm_hold_vld got=%b exp=00", o_dbg_hold_vld); end
        total++; if (o_dbg_state !== 1'b0) begin bad++; $display("FAIL rm_state got=%0b exp=0", o_dbg_state); end
        mHREADY = 1'b1;
        step();
        #1;
        total++; if (mHTRANS !== 2'b00) begin bad++; $display("FAIL rm_no_replay got=%0h exp=0", mHTRANS); end
    endtask

`ifdef AHB3LITE_MASTER_ARB_LOCK_EN
    task automatic test_lock();
        logic exp_grant [8];
        logic exp_lock  [8];
        logic got;
        logic will0;
        int   n;
        int   sent0;
        exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_lock  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        n     = 0;
        sent0 = 0;
        do_reset();
        sHTRANS[0] = 2'b10; sHADDR[0] = 32'h1000; sHMASTLOCK[0] = 1'b1;
        sHTRANS[1] = 2'b10; sHADDR[1] = 32'h2000; sHMASTLOCK[1] = 1'b0;
        for (int c = 0; c < 80 && n < 8; c++) begin
            #1;
            will0 = sHREADYOUT[0] & sHTRANS[0][1];
            if (mHTRANS == 2'b10) begin
                got = (mHADDR == 32'h2000);
                total++;
                if (got !== exp_grant[n]) begin bad++; $display("FAIL lk_grant%0d got=%0b exp=%0b", n, got, exp_grant[n]); end
                total++;
                if (mHMASTLOCK !== exp_lock[n]) begin bad++; $display("FAIL lk_lock%0d got=%0b exp=%0b", n, mHMASTLOCK, exp_lock[n]); end
                n++;
            end
            step();
            if (will0) sent0++;
            sHTRANS[0]    = (sent0 < 7) ? 2'b10 : 2'b00;
            sHMASTLOCK[0] = (sent0 < 6);
        end
        total++; if (n != 8) begin bad++; $display("FAIL lk_timeout got=%0d exp=8", n); end
        sHTRANS = '0;
    endtask
`endif

    initial begin
        rst_i = 1'b1;
        test_reset();
        test_single_write();
        test_round_robin();
        test_error();
        test_reset_mid();
`ifdef AHB3LITE_MASTER_ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
